dispatch_ctrl: RTL

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// Instruction dispatcher: routes decoded instructions to ROB/RS/LSB, with a one-entry hold buffer.
// Optional macro DISPATCH_BR_STALL_EN stalls fetch after every branch/JALR until br_resolved.
module dispatch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        dec_valid,
   input  logic [6:0]  dec_ophead,
   input  logic [5:0]  dec_opcode,
   output logic        dec_ready,
   input  logic        rob_full,
   input  logic        rs_full,
   input  logic        lsb_full,
   input  logic [3:0]  rob_tag,
   input  logic        br_resolved,
   input  logic        flush,
   output logic        issue_rob,
   output logic        issue_rs,
   output logic        issue_lsb,
   output logic [3:0]  issue_tag,
   output logic [5:0]  issue_opcode,
   output logic [31:0] issue_cnt
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_BR_WAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RT_RS       = 2'd0,
      RT_LSB      = 2'd1,
      RT_ROB_ONLY = 2'd2
   } route_e;

`ifdef DISPATCH_BR_STALL_EN
   localparam bit BR_STALL = 1'b1;
`else
   localparam bit BR_STALL = 1'b0;
`endif

   function automatic route_e route_of(input logic [6:0] op);
      route_e r;
      case (op)
         7'b0000011, 7'b0100011:             r = RT_LSB;
         7'b0110111, 7'b0010111, 7'b1101111: r = RT_ROB_ONLY;
         default:                            r = RT_RS;
      endcase
      return r;
   endfunction

   function automatic logic is_branch(input logic [6:0] op);
      return (op == 7'b1100011) || (op == 7'b1100111);
   endfunction

   state_e      state_q, state_d;
   logic        buf_valid_q, buf_valid_d;
   logic [6:0]  buf_ophead_q, buf_ophead_d;
   logic [5:0]  buf_opcode_q, buf_opcode_d;
   logic        issue_rob_q, issue_rob_d;
   logic        issue_rs_q, issue_rs_d;
   logic        issue_lsb_q, issue_lsb_d;
   logic [3:0]  issue_tag_q, issue_tag_d;
   logic [5:0]  issue_opcode_q, issue_opcode_d;
   logic [31:0] issue_cnt_q, issue_cnt_d;

   logic        accept;
   logic [6:0]  sel_ophead;
   logic [5:0]  sel_opcode;
   route_e      sel_route;
   logic        sel_space;
   state_e      post_issue_state;

   assign dec_ready = (state_q == ST_RUN) && !flush && rdy;
   assign accept    = dec_ready && dec_valid;

   // In HOLD the buffered instruction competes for space; in RUN the decoder's one does.
   assign sel_ophead = (state_q == ST_HOLD) ? buf_ophead_q : dec_ophead;
   assign sel_opcode = (state_q == ST_HOLD) ? buf_opcode_q : dec_opcode;
   assign sel_route  = route_of(sel_ophead);

   always_comb begin
      sel_space = !rob_full;
      case (sel_route)
         RT_RS:   sel_space = !rob_full && !rs_full;
         RT_LSB:  sel_space = !rob_full && !lsb_full;
         default: sel_space = !rob_full;
      endcase
   end

   assign post_issue_state = (BR_STALL && is_branch(sel_ophead)) ? ST_BR_WAIT : ST_RUN;

   always_comb begin
      state_d        = state_q;
      buf_valid_d    = buf_valid_q;
      buf_ophead_d   = buf_ophead_q;
      buf_opcode_d   = buf_opcode_q;
      issue_rob_d    = 1'b0;
      issue_rs_d     = 1'b0;
      issue_lsb_d    = 1'b0;
      issue_tag_d    = issue_tag_q;
      issue_opcode_d = issue_opcode_q;
      issue_cnt_d    = issue_cnt_q;

      if (!rdy) begin
         // Frozen: a pending pulse survives until rdy returns, so it is seen exactly once.
         issue_rob_d = issue_rob_q;
         issue_rs_d  = issue_rs_q;
         issue_lsb_d = issue_lsb_q;
      end else if (flush) begin
         state_d     = ST_RUN;
         buf_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (accept) begin
                  if (sel_space) begin
                     issue_rob_d    = 1'b1;
                     issue_rs_d     = (sel_route == RT_RS);
                     issue_lsb_d    = (sel_route == RT_LSB);
                     issue_tag_d    = rob_tag;
                     issue_opcode_d = sel_opcode;
                     issue_cnt_d    = issue_cnt_q + 32'd1;
                     state_d        = post_issue_state;
                  end else begin
                     buf_valid_d  = 1'b1;
                     buf_ophead_d = dec_ophead;
                     buf_opcode_d = dec_opcode;
                     state_d      = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (sel_space) begin
                  issue_rob_d    = 1'b1;
                  issue_rs_d     = (sel_route == RT_RS);
                  issue_lsb_d    = (sel_route == RT_LSB);
                  issue_tag_d    = rob_tag;
                  issue_opcode_d = sel_opcode;
                  issue_cnt_d    = issue_cnt_q + 32'd1;
                  buf_valid_d    = 1'b0;
                  state_d        = post_issue_state;
               end
            end
            ST_BR_WAIT: begin
               if (!BR_STALL || br_resolved) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d     = ST_RUN;
               buf_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         buf_valid_q    <= 1'b0;
         buf_ophead_q   <= 7'd0;
         buf_opcode_q   <= 6'd0;
         issue_rob_q    <= 1'b0;
         issue_rs_q     <= 1'b0;
         issue_lsb_q    <= 1'b0;
         issue_tag_q    <= 4'd0;
         issue_opcode_q <= 6'd0;
         issue_cnt_q    <= 32'd0;
      end else begin
         state_q        <= state_d;
         buf_valid_q    <= buf_valid_d;
         buf_ophead_q   <= buf_ophead_d;
         buf_opcode_q   <= buf_opcode_d;
         issue_rob_q    <= issue_rob_d;
         issue_rs_q     <= issue_rs_d;
         issue_lsb_q    <= issue_lsb_d;
         issue_tag_q    <= issue_tag_d;
         issue_opcode_q <= issue_opcode_d;
         issue_cnt_q    <= issue_cnt_d;
      end
   end

   assign issue_rob    = issue_rob_q && rdy;
   assign issue_rs     = issue_rs_q && rdy;
   assign issue_lsb    = issue_lsb_q && rdy;
   assign issue_tag    = issue_tag_q;
   assign issue_opcode = issue_opcode_q;
   assign issue_cnt    = issue_cnt_q;

endmodule
